// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-port ALU sequencer: FSM encoding, ALU
// function codes and the illegal-operation check.
package alu_share_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1011;

  // Any F[2:0] with bit 2 set has no ALU function behind it.
  localparam logic [2:0] ILLEGAL_MASK = 3'b100;

  function automatic logic is_illegal(input logic [2:0] op);
    return (op & ILLEGAL_MASK) != 3'b000;
  endfunction

endpackage

// File: rtl/alu_share_arb_alu32.sv
// 32-bit ALU core: AND, OR, ADD/SUB and SLT, with F[3] inverting B and
// supplying the carry-in.
module alu32
  import alu_share_arb_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  f,
  output logic [31:0] y
);

  logic [31:0] b_eff;
  logic [31:0] sum;

  assign b_eff = f[3] ? ~b : b;
  assign sum   = a + b_eff + {31'b0, f[3]};

  always_comb begin
    y = 32'd0;
    case (f[2:0])
      ALU_AND[2:0]: y = a & b_eff;
      ALU_OR[2:0]:  y = a | b_eff;
      ALU_ADD[2:0]: y = sum;
      // Raw sign of the difference; overflow deliberately left uncorrected.
      ALU_SLT[2:0]: y = {31'b0, sum[31]};
      default:      y = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two-port arbitrated sequencer sharing one alu32: one transaction in flight,
// IDLE -> EXEC -> RESP, result held for the owning port until consumed.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_a,
  input  logic [31:0] p0_b,
  input  logic [3:0]  p0_f,
  output logic        p0_rsp_valid,
  input  logic        p0_rsp_ready,
  output logic [31:0] p0_rsp_y,
  output logic        p0_rsp_err,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_a,
  input  logic [31:0] p1_b,
  input  logic [3:0]  p1_f,
  output logic        p1_rsp_valid,
  input  logic        p1_rsp_ready,
  output logic [31:0] p1_rsp_y,
  output logic        p1_rsp_err
);

  state_t      state_reg;
  logic        last_win_reg;
  logic        owner_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [3:0]  f_reg;
  logic [31:0] res_reg;
  logic        err_reg;
  logic [31:0] alu_y;
  logic        grant0;
  logic        grant1;
  logic        idle;
  logic        in_resp;
  logic        owner_rsp_ready;

  alu32 u_alu (
    .a (a_reg),
    .b (b_reg),
    .f (f_reg),
    .y (alu_y)
  );

  // last_win_reg = 1 means port 1 won the previous accept, so port 0 wins a tie.
  assign grant0 = p0_valid && (!p1_valid || (FIXED_PRIORITY != 0) || last_win_reg);
  assign grant1 = p1_valid && !grant0;

  assign idle     = (state_reg == ST_IDLE);
  assign in_resp  = (state_reg == ST_RESP);
  assign p0_ready = reset_n && idle && grant0;
  assign p1_ready = reset_n && idle && grant1;

  assign owner_rsp_ready = owner_reg ? p1_rsp_ready : p0_rsp_ready;

  assign p0_rsp_valid = in_resp && !owner_reg;
  assign p1_rsp_valid = in_resp && owner_reg;
  assign p0_rsp_y     = p0_rsp_valid ? res_reg : 32'd0;
  assign p1_rsp_y     = p1_rsp_valid ? res_reg : 32'd0;
  assign p0_rsp_err   = p0_rsp_valid && err_reg;
  assign p1_rsp_err   = p1_rsp_valid && err_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      last_win_reg <= 1'b1;
      owner_reg    <= 1'b0;
      a_reg        <= 32'd0;
      b_reg        <= 32'd0;
      f_reg        <= 4'd0;
      res_reg      <= 32'd0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            owner_reg    <= grant1;
            last_win_reg <= grant1;
            a_reg        <= grant1 ? p1_a : p0_a;
            b_reg        <= grant1 ? p1_b : p0_b;
            f_reg        <= grant1 ? p1_f : p0_f;
            state_reg    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_illegal(f_reg[2:0])) begin
            res_reg <= 32'd0;
            err_reg <= 1'b1;
          end else begin
            res_reg <= alu_y;
            err_reg <= 1'b0;
          end
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          if (owner_rsp_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Arbitrated sequencer that shares the single 32-bit `alu32` core between two requesters: port 0, the pipeline's multi-cycle/stall-path helper, and port 1, the DES round/key-schedule engine. It accepts one operation at a time through a valid/ready handshake and drives the ALU from registered operands. It returns a registered result with an illegal-op flag to the owning port and holds that result until the port consumes it.

## Interface
- `FIXED_PRIORITY`, default 0: 0 = round-robin between ports; 1 = port 0 always wins a tie.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `p0_valid` / `p1_valid` in 1: request present.
- `p0_ready` / `p1_ready` out 1: request accepted this cycle when high with valid.
- `p0_a`, `p0_b` / `p1_a`, `p1_b` in 32: ALU source operands A and B.
- `p0_f` / `p1_f` in 4: ALU control. F[3] inverts B and adds carry-in. F[2:0] selects: 000 AND, 001 OR, 010 ADD/SUB, 011 SLT.
- `p0_rsp_valid` / `p1_rsp_valid` out 1: result available.
- `p0_rsp_ready` / `p1_rsp_ready` in 1: result consumed when high with rsp_valid.
- `p0_rsp_y` / `p1_rsp_y` out 32: result.
- `p0_rsp_err` / `p1_rsp_err` out 1: F[2:0] was illegal (1xx).

## Operation
- FSM states: IDLE, EXEC, RESP. At most one transaction is outstanding.
- IDLE
  - Arbitrate among valid ports and raise ready only to the winner. Ready depends combinationally on the valids and the state only.
  - On accept: capture a/b/f and the owner id, then go to EXEC.
- Arbitration
  - Single requester: that port wins.
  - Both valid, FIXED_PRIORITY=0: the port that did not win the last accept wins.
  - Both valid, FIXED_PRIORITY=1: port 0 wins.
  - The last-winner pointer updates only on accept. It resets to 1, so port 0 wins the first tie.
- EXEC (exactly 1 cycle)
  - `alu32` is driven from the captured operands.
  - Legal F[2:0]: the ALU output is registered into the result register and err=0.
  - Illegal F[2:0]: the result register is loaded with 0 and err=1. The ALU's undriven output is never propagated.
  - Then go to RESP.
- RESP
  - Assert rsp_valid of the owner port only. The other port's rsp_valid stays 0.
  - rsp_y and rsp_err are driven from the result register for the owner; the non-owner port's rsp_y and rsp_err are 0.
  - On rsp_ready, go to IDLE. Both ready outputs stay 0 throughout RESP.
- Arithmetic
  - 32-bit, modulo 2^32; carry and overflow are discarded.
  - SUB = A + ~B + 1.
  - SLT returns {31'b0, sum[31]}. This is the signed-difference sign bit; overflow is not corrected, and the bench checks this exact behaviour.
- Boundary conditions
  - A requester may drop valid before it is granted; no handshake is implied.
  - Inputs are ignored outside IDLE.
  - rsp_ready asserted while rsp_valid is low is ignored.
- Reset
  - Any state returns to IDLE on the next edge. An in-flight transaction is discarded with no response.
  - The pointer resets to 1.
  - The result register, err, and owner register reset to 0.

## Timing
- Reset values:
  - All ready outputs 0 during reset. From IDLE they follow the arbitration.
  - All rsp_valid 0, all rsp_y 0, all rsp_err 0.
- Latency: accept at edge N, EXEC during cycle N+1, rsp_valid high from the cycle after edge N+1. That is 2 cycles from accept to response.
- Throughput: with rsp_ready tied high, one operation per 3 cycles:
  - the accept cycle in IDLE;
  - one cycle in EXEC;
  - one cycle in RESP, consumed;
  - then back to IDLE.
- RESP holds rsp_y and rsp_err stable for as many cycles as rsp_ready stays low.
- No combinational path from rsp_ready to any ready output within the same cycle, because ready is 0 in RESP.

## Structure
- Shared package holds:
  - state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - the ALU function constants: AND, OR, ADD, SUB, SLT;
  - the illegal-op mask (F[2]=1).
- One sub-module: `alu32`, instantiated once and fed only from the captured operand registers.
- The arbiter is inline logic, not a separate module.

## Test plan
- Basic ADD: p0 sends a=5, b=7, f=0010 → p0_rsp_valid two cycles after accept, y=12, err=0. p1 sees no response.
- SUB/SLT: p1 sends a=3, b=5, f=1010 → y=0xFFFFFFFE. Then a=3, b=5, f=1011 → y=1. Then a=0x80000000, b=1, f=1011 → y=0, the uncorrected overflow case.
- Arbitration, FIXED_PRIORITY=0:
  - Both ports hold valid continuously with rsp_ready=1.
  - Grants go p0, p1, p0, p1, one accept every 3 cycles.
  - Repeat with FIXED_PRIORITY=1 → every grant goes to p0.
- Backpressure: p0 ADD a=0xFFFFFFFF, b=1 → y=0. Hold rsp_ready low for 4 cycles:
  - y stays 0 and rsp_valid stays 1;
  - both ready outputs stay 0, with p1 valid high;
  - after the release, p1 is granted on the next cycle.
- Illegal op: p1 sends f=0100 with a=0xA5A5A5A5 → y=0, err=1. The next legal op clears err.
- Reset mid-operation: assert reset_n=0 during EXEC → no rsp_valid ever appears for that transaction. After release, all outputs are 0 and the first tie goes to p0.
